cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 6, number of functional-unit result sources, indexed 1..NUM_FU; index 0 is unused.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ex_cdb_packet  input  EX_CDB_PACKET  per-FU results fu_out_packets[1..NUM_FU], each carrying done, rob_tag, result (XLEN).
REQ-005 squash_packet  input  SQUASH_PACKET  squash_valid plus rob_tag of the mispredicted branch.
REQ-006 cdb_packet  output  CDB_PACKET  registered broadcast: valid, rob_tag, value (XLEN), fu_idx.
REQ-007 cdb_ex_packet  output  CDB_EX_PACKET  ack[NUM_FU:0], one-hot-or-zero grant back to the FUs.

Function
REQ-008 A FU i is a requester in a cycle iff fu_out_packets[i].done=1.
REQ-009 ack is combinational from the current requesters, the priority pointer and squash_valid; at most one ack bit is 1 per cycle.
REQ-010 ack[0] is always 0; ack[i]=1 only when FU i is a requester.
REQ-011 Grant is round-robin: the first requester found scanning upward from pointer ptr (range 1..NUM_FU), wrapping NUM_FU->1.
REQ-012 After a grant to FU g, ptr takes g+1 on the next edge, and 1 when g=NUM_FU; with no grant, ptr holds.
REQ-013 The granted FU's rob_tag and result are registered into cdb_packet on the same edge, with valid=1 and fu_idx=g; latency is one cycle from ack to broadcast.
REQ-014 With no grant, cdb_packet.valid=0 next cycle; rob_tag, value and fu_idx are 0.
REQ-015 FUs hold done and data until acked; the arbiter keeps no copy of unacked results.
REQ-016 When squash_valid=1: all ack bits are 0, cdb_packet clears to 0 on the next edge, and ptr returns to 1.
REQ-017 Squash has priority over any simultaneous request, including the requester raising the squash.
REQ-018 Starvation bound: a continuously requesting FU is acked within NUM_FU cycles in the absence of squash.
REQ-019 Counter grant_cnt (32 bit, internal, debug-visible) increments per grant and wraps 2^32-1 -> 0.

Reset
REQ-020 On reset, cdb_packet=0, ptr=1 and grant_cnt=0.
REQ-021 While reset is high, all ack bits are 0.
REQ-022 Reset asserted mid-stream discards the pending broadcast with no ack issued.
REQ-023 On the first cycle after reset deasserts, normal arbitration starts from ptr=1.

Structure
REQ-024 NUM_FU, EX_CDB_PACKET, FU_OUT_PACKET, CDB_PACKET, CDB_EX_PACKET and SQUASH_PACKET live in sys_defs.svh and are shared with ex and the ROB/RS.
REQ-025 Round-robin selection is a sub-module rr_select (request vector and pointer in, one-hot grant out), purely combinational.
REQ-026 cdb_arbiter holds all state: ptr, the cdb_packet register and grant_cnt.

Verification
REQ-027 Reset 3 cycles, no requests -> ack=0, cdb_packet.valid=0, ptr=1.
REQ-028 Only FU3 done, tag 5, result 0xDEAD -> ack[3]=1 that cycle; next cycle cdb valid, tag 5, value 0xDEAD, fu_idx 3; ptr=4.
REQ-029 FUs 1, 2 and 5 done and held high for 3 cycles from ptr=1 -> grant order 1, 2, 5, each broadcast one cycle later.
REQ-030 ptr=6, FUs 6 and 1 requesting -> FU6 granted, then ptr=1 and FU1 granted next cycle (wrap).
REQ-031 FU2 done with squash_valid=1 in the same cycle -> ack=0, next-cycle cdb valid=0, ptr=1.
REQ-032 All 6 FUs requesting continuously for 12 cycles -> each acked exactly twice, grant_cnt=12.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: per-FU result packets, squash, broadcast and ack vectors.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU_DEFAULT = 6;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned ROB_TAG_W      = 5;
    localparam int unsigned FU_IDX_W       = $clog2(NUM_FU_DEFAULT + 1);

    typedef struct packed {
        logic                 done;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      result;
    } fu_out_packet_t;

    // Entry 0 exists only so FU indices run 1..NUM_FU; it is never a requester.
    typedef struct packed {
        fu_out_packet_t [NUM_FU_DEFAULT:0] fu_out_packets;
    } ex_cdb_packet_t;

    typedef struct packed {
        logic                 squash_valid;
        logic [ROB_TAG_W-1:0] rob_tag;
    } squash_packet_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      value;
        logic [FU_IDX_W-1:0]  fu_idx;
    } cdb_packet_t;

    typedef struct packed {
        logic [NUM_FU_DEFAULT:0] ack;
    } cdb_ex_packet_t;

    // Pointer value following a grant to FU g: g+1, wrapping NUM_FU back to 1.
    function automatic logic [FU_IDX_W-1:0] rr_next_ptr(input logic [FU_IDX_W-1:0] g,
                                                        input int unsigned         num_fu);
        if (int'(g) == int'(num_fu)) begin
            return FU_IDX_W'(1);
        end
        return g + FU_IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker over requesters 1..NUM_FU starting at ptr_i.
module rr_select #(
    parameter int unsigned NUM_FU = 6,
    parameter int unsigned IDX_W  = $clog2(NUM_FU + 1)
) (
    input  logic [NUM_FU:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NUM_FU:0]  grant_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;

    // Scan NUM_FU slots upward from ptr_i, wrapping NUM_FU -> 1; first requester wins.
    always_comb begin
        grant_o     = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        sum         = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, ptr_i} + SUM_W'(k);
            if (sum > SUM_W'(NUM_FU)) begin
                sum = sum - SUM_W'(NUM_FU);
            end
            cand = sum[IDX_W-1:0];
            if (!gnt_valid_o && req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        if (gnt_valid_o) begin
            grant_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among finished FUs, one registered
// broadcast per cycle, squash flushes the bus and rewinds the pointer.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    // Packet widths follow NUM_FU_DEFAULT; keep this equal to it.
    parameter int unsigned NUM_FU = NUM_FU_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  ex_cdb_packet_t ex_cdb_packet,
    input  squash_packet_t squash_packet,
    output cdb_packet_t    cdb_packet,
    output cdb_ex_packet_t cdb_ex_packet
);

    localparam int unsigned IDX_W = FU_IDX_W;

    logic [NUM_FU:0]  req;
    logic [NUM_FU:0]  grant;
    logic [NUM_FU:0]  ack;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             blocked;
    fu_out_packet_t   gnt_pkt;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    cdb_packet_t      cdb_q, cdb_d;
    logic [31:0]      grant_cnt_q, grant_cnt_d;

    assign req[0] = 1'b0;
    for (genvar i = 1; i <= NUM_FU; i++) begin : g_req
        assign req[i] = ex_cdb_packet.fu_out_packets[i].done;
    end

    rr_select #(
        .NUM_FU (NUM_FU),
        .IDX_W  (IDX_W)
    ) u_rr_select (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Squash outranks every requester, including the one raising the squash.
    assign blocked           = reset | squash_packet.squash_valid;
    assign ack               = blocked ? '0 : grant;
    assign cdb_ex_packet.ack = ack;
    assign gnt_pkt           = ex_cdb_packet.fu_out_packets[gnt_idx];
    assign cdb_packet        = cdb_q;

    // Next-state: latch the granted result, advance the pointer, count grants.
    always_comb begin
        cdb_d       = '0;
        ptr_d       = ptr_q;
        grant_cnt_d = grant_cnt_q;
        if (squash_packet.squash_valid) begin
            ptr_d = IDX_W'(1);
        end else if (gnt_valid) begin
            cdb_d.valid   = 1'b1;
            cdb_d.rob_tag = gnt_pkt.rob_tag;
            cdb_d.value   = gnt_pkt.result;
            cdb_d.fu_idx  = gnt_idx;
            ptr_d         = rr_next_ptr(gnt_idx, NUM_FU);
            grant_cnt_d   = grant_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous reset; reset drops any pending broadcast.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_q       <= '0;
            ptr_q       <= IDX_W'(1);
            grant_cnt_q <= '0;
        end else begin
            cdb_q       <= cdb_d;
            ptr_q       <= ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    // Squash tag and FU slot 0 carry no meaning for arbitration.
    logic unused_inputs;
    assign unused_inputs = ^{squash_packet.rob_tag, ex_cdb_packet.fu_out_packets[0]};

endmodule
